// File: rtl/nasti_mem_slave.sv
// nasti_mem_slave
//   NASTI (AXI4) slave backed by an on-chip word-addressed memory. It serves
//   INCR read and write bursts of up to 256 beats. One burst is outstanding
//   per direction, and the read and write channels run independently.
//
// Ports
//   aclk, aresetn             clock; asynchronous active-low reset
//   i_s_ar_* / o_s_ar_ready   read address channel (id, addr, len)
//   o_s_r_* / i_s_r_ready     read data channel (id, data, resp, last)
//   i_s_aw_* / o_s_aw_ready   write address channel (id, addr, len)
//   i_s_w_* / o_s_w_ready     write data channel (data, strb, last)
//   o_s_b_* / i_s_b_ready     write response channel (id, resp)
//   size, burst, cache, prot and lock carry no meaning here and are not ports.
//
// Configuration
//   NASTI_MEM_RANGE_CHECK_EN  when defined, beats at byte address >= MEM_BYTES
//                             (full-width compare) return SLVERR; reads give
//                             zero data and writes are dropped. When undefined,
//                             addresses alias modulo MEM_BYTES.
module nasti_mem_slave #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_BYTES  = 65536
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    i_s_ar_valid,
  output logic                    o_s_ar_ready,
  input  logic [ID_WIDTH-1:0]     i_s_ar_id,
  input  logic [ADDR_WIDTH-1:0]   i_s_ar_addr,
  input  logic [7:0]              i_s_ar_len,
  output logic                    o_s_r_valid,
  input  logic                    i_s_r_ready,
  output logic [ID_WIDTH-1:0]     o_s_r_id,
  output logic [DATA_WIDTH-1:0]   o_s_r_data,
  output logic [1:0]              o_s_r_resp,
  output logic                    o_s_r_last,
  input  logic                    i_s_aw_valid,
  output logic                    o_s_aw_ready,
  input  logic [ID_WIDTH-1:0]     i_s_aw_id,
  input  logic [ADDR_WIDTH-1:0]   i_s_aw_addr,
  input  logic [7:0]              i_s_aw_len,
  input  logic                    i_s_w_valid,
  output logic                    o_s_w_ready,
  input  logic [DATA_WIDTH-1:0]   i_s_w_data,
  input  logic [DATA_WIDTH/8-1:0] i_s_w_strb,
  input  logic                    i_s_w_last,
  output logic                    o_s_b_valid,
  input  logic                    i_s_b_ready,
  output logic [ID_WIDTH-1:0]     o_s_b_id,
  output logic [1:0]              o_s_b_resp
);

  localparam int WORDS    = MEM_BYTES / 8;
  localparam int MEM_LOG2 = $clog2(MEM_BYTES);
  localparam int IDX_W    = (MEM_LOG2 > 3) ? (MEM_LOG2 - 3) : 1;
  localparam logic [IDX_W-1:0]      IDX_MASK   = IDX_W'(WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_FETCH = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;
  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_DATA  = 2'd1;
  localparam logic [1:0] W_RESP  = 2'd2;

  logic [DATA_WIDTH-1:0] r_mem [0:WORDS-1];

  logic [1:0]            r_rstate;
  logic [ID_WIDTH-1:0]   r_ar_id;
  logic [ADDR_WIDTH-1:0] r_ar_addr;
  logic [7:0]            r_ar_len;
  logic [7:0]            r_rbeat;
  logic                  r_rlast;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic [1:0]            r_wstate;
  logic [ID_WIDTH-1:0]   r_aw_id;
  logic [ADDR_WIDTH-1:0] r_aw_addr;
  logic [7:0]            r_aw_len;
  logic [7:0]            r_wbeat;
  logic                  r_werr;
  logic [1:0]            r_bresp;

  logic [IDX_W-1:0]      w_ridx;
  logic [IDX_W-1:0]      w_widx;
  logic                  w_r_oor;
  logic                  w_w_oor;
  logic                  w_w_hs;
  logic                  w_w_final;
  logic                  w_werr_nxt;
  logic                  w_wr_en;

  // Word index drops the byte offset; the mask keeps aliasing modulo MEM_BYTES.
  assign w_ridx = r_ar_addr[IDX_W+2:3] & IDX_MASK;
  assign w_widx = r_aw_addr[IDX_W+2:3] & IDX_MASK;

`ifdef NASTI_MEM_RANGE_CHECK_EN
  assign w_r_oor = (r_ar_addr >> MEM_LOG2) != {ADDR_WIDTH{1'b0}};
  assign w_w_oor = (r_aw_addr >> MEM_LOG2) != {ADDR_WIDTH{1'b0}};
`else
  assign w_r_oor = 1'b0;
  assign w_w_oor = 1'b0;
`endif

  assign w_w_hs     = (r_wstate == W_DATA) && i_s_w_valid;
  assign w_w_final  = (r_wbeat == r_aw_len) || i_s_w_last;
  // A w_last that disagrees with the beat count, in either direction, is sticky.
  assign w_werr_nxt = r_werr || (i_s_w_last != (r_wbeat == r_aw_len)) || w_w_oor;
  assign w_wr_en    = w_w_hs && !w_w_oor;

  assign o_s_ar_ready = (r_rstate == R_IDLE);
  assign o_s_r_valid  = (r_rstate == R_DATA);
  assign o_s_r_id     = r_ar_id;
  assign o_s_r_data   = r_rdata;
  assign o_s_r_resp   = r_rresp;
  assign o_s_r_last   = r_rlast;
  assign o_s_aw_ready = (r_wstate == W_IDLE);
  assign o_s_w_ready  = (r_wstate == W_DATA);
  assign o_s_b_valid  = (r_wstate == W_RESP);
  assign o_s_b_id     = r_aw_id;
  assign o_s_b_resp   = r_bresp;

  // Memory array: byte-masked write port and registered read port (no reset).
  always_ff @(posedge aclk) begin
    if (r_rstate == R_FETCH) begin
      r_rdata <= w_r_oor ? {DATA_WIDTH{1'b0}} : r_mem[w_ridx];
    end
    for (int i = 0; i < DATA_WIDTH / 8; i++) begin
      if (w_wr_en && i_s_w_strb[i]) begin
        r_mem[w_widx][8*i +: 8] <= i_s_w_data[8*i +: 8];
      end
    end
  end

  // Read FSM: accept address, then alternate fetch / present one beat.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rstate  <= R_IDLE;
      r_ar_id   <= '0;
      r_ar_addr <= '0;
      r_ar_len  <= 8'd0;
      r_rbeat   <= 8'd0;
      r_rlast   <= 1'b0;
      r_rresp   <= RESP_OKAY;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (i_s_ar_valid) begin
            r_ar_id   <= i_s_ar_id;
            r_ar_addr <= i_s_ar_addr;
            r_ar_len  <= i_s_ar_len;
            r_rbeat   <= 8'd0;
            r_rstate  <= R_FETCH;
          end
        end
        R_FETCH: begin
          // Last and resp are registered alongside the data so the beat is stable.
          r_rlast  <= (r_rbeat == r_ar_len);
          r_rresp  <= w_r_oor ? RESP_SLVERR : RESP_OKAY;
          r_rstate <= R_DATA;
        end
        R_DATA: begin
          if (i_s_r_ready) begin
            if (r_rlast) begin
              r_rstate <= R_IDLE;
            end else begin
              r_ar_addr <= r_ar_addr + BEAT_BYTES;
              r_rbeat   <= r_rbeat + 8'd1;
              r_rstate  <= R_FETCH;
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // Write FSM: accept address, absorb one beat per cycle, then respond.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wstate  <= W_IDLE;
      r_aw_id   <= '0;
      r_aw_addr <= '0;
      r_aw_len  <= 8'd0;
      r_wbeat   <= 8'd0;
      r_werr    <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (i_s_aw_valid) begin
            r_aw_id   <= i_s_aw_id;
            r_aw_addr <= i_s_aw_addr;
            r_aw_len  <= i_s_aw_len;
            r_wbeat   <= 8'd0;
            r_werr    <= 1'b0;
            r_wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_w_hs) begin
            r_werr <= w_werr_nxt;
            if (w_w_final) begin
              r_bresp  <= w_werr_nxt ? RESP_SLVERR : RESP_OKAY;
              r_wstate <= W_RESP;
            end else begin
              r_aw_addr <= r_aw_addr + BEAT_BYTES;
              r_wbeat   <= r_wbeat + 8'd1;
            end
          end
        end
        W_RESP: begin
          if (i_s_b_ready) begin
            r_wstate <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

endmodule

// File: doc/nasti_mem_slave.md
# nasti_mem_slave

NASTI (AXI4) slave that backs a single NASTI port with an on-chip word-addressed memory array, serving INCR read and write bursts of up to 256 beats. It is the responder counterpart to the `data_mover` block: one mover port can target it as the `src` (read) end, the `dest` (write) end, or both. Use it as a scratchpad target and as a standalone burst responder for testing masters. One burst is outstanding per direction, and the read and write channels run concurrently.

## Interface
- ADDR_WIDTH, 64: NASTI address width.
- DATA_WIDTH, 64: NASTI data width. Must be 64; beat size is DATA_WIDTH/8 bytes.
- ID_WIDTH, 4: NASTI ID width.
- MEM_BYTES, 65536: memory size in bytes. Must be a power of two and at least 8.
- aclk  in  1  clock.
- aresetn  in  1  reset: asynchronous, active-low.
- s  nasti_channel.slave  -  slave port.
  - Channels used: ar, r, aw, w, b.
  - ar_size/aw_size, ar_burst/aw_burst, cache, prot and lock are ignored.

## Operation
- Memory:
  - WORDS = MEM_BYTES/8 words, indexed by addr[log2(MEM_BYTES)-1:3].
  - Address bits [2:0] are dropped, so every beat is word-aligned.
  - The array has one write port and one registered read port.
  - Memory contents are not reset.
- Read FSM, states R_IDLE, R_FETCH, R_DATA:
  - R_IDLE: ar_ready=1. On ar_valid&ar_ready, latch ar_id, ar_addr and ar_len, clear the beat counter, then go to R_FETCH.
  - R_FETCH: issue the array read at the current word, then go to R_DATA.
  - R_DATA: drive r_valid=1 with r_data, r_id=latched id, r_resp and r_last=(beat==len). Hold all of them stable until r_ready.
  - On handshake: if last, go to R_IDLE. Otherwise increment the word address and beat counter and go to R_FETCH.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: aw_ready=1. On aw_valid&aw_ready, latch aw_id, aw_addr and aw_len, then go to W_DATA.
  - W_DATA: w_ready=1. Each w handshake writes w_data to the current word, byte-masked by w_strb, then increments the address and beat counter.
  - The burst ends on the beat where beat==len, or earlier if w_last is asserted; then go to W_RESP.
  - W_RESP: b_valid=1, b_id=latched id. b_resp is OKAY (2'b00), except SLVERR (2'b10) when w_last disagreed with beat==len on any beat.
  - W_RESP to W_IDLE on b_ready.
- Address arithmetic:
  - Burst word addresses are start+beat, where beat ranges over 0..len.
  - The increment is done in ADDR_WIDTH bits.
  - No 4 KB boundary check is made.
- Same word read and written in the same cycle: the read returns the old data. A write is visible to a fetch issued from the next cycle on.
- No ordering is enforced between the read and write channels.
- Reset mid-burst: both FSMs return to IDLE, all valids drop asynchronously, and the burst is abandoned with no response. Memory contents are retained.

## Timing
- Reset values:
  - r_valid=0, b_valid=0, r_last=0, r_resp=0, b_resp=0, r_id=0, b_id=0.
  - ar_ready=1 and aw_ready=1 (decoded from the IDLE states).
  - w_ready=0.
- Read:
  - The ar handshake in cycle N gives first r_valid in cycle N+2.
  - After an r handshake in cycle M, the next r_valid is in cycle M+2.
  - Peak rate is 1 beat per 2 cycles.
- Write:
  - The aw handshake in cycle N gives w_ready in cycle N+1.
  - Rate is 1 beat per cycle.
  - b_valid is asserted the cycle after the final w handshake.
- ar_ready is 0 from R_FETCH onwards until the burst's last r handshake.
- aw_ready is 0 from W_DATA onwards until the b handshake.
- valid is never withdrawn before ready; payload is stable while valid && !ready.

## Configuration
- NASTI_MEM_RANGE_CHECK_EN:
  - Defined: the check is against the full ADDR_WIDTH address.
  - Any beat whose byte address is >= MEM_BYTES is an out-of-range beat.
    - Read: r_data=0, r_resp=SLVERR.
    - Write: the beat is suppressed and b_resp=SLVERR.
  - Undefined: upper address bits are ignored, accesses alias modulo MEM_BYTES, and only OKAY is returned (apart from the w_last-mismatch SLVERR).

## Test plan
- Write then read back:
  - AW addr 0x100, len 3, data 0x11..0x44, strb 0xFF -> b_resp OKAY, b_id matches aw_id.
  - Then AR addr 0x100, len 3 -> r_data 0x11,0x22,0x33,0x44, r_last on beat 3 only.
- Byte strobes: write 0xFFFF_FFFF_FFFF_FFFF to 0x0, then write 0x0 with strb 0x0F -> read 0x0 returns 0xFFFF_FFFF_0000_0000.
- Max burst with backpressure:
  - Write len 255 with w_valid toggling every other cycle, then read len 255 with r_ready low 3 of every 4 cycles.
  - -> 256 beats intact, exactly one r_last, payload stable while stalled.
- Concurrent channels: a read burst of 0x200 len 7 and a write burst of 0x800 len 7 are issued in the same cycle -> both complete, and the read data equals the prior contents.
- w_last mismatch: aw len 3 with w_last on beat 1 -> burst ends after 2 beats, b_resp=SLVERR, and words 2-3 are unchanged.
- Range check and reset:
  - With NASTI_MEM_RANGE_CHECK_EN, MEM_BYTES 65536: AR addr 0x10000 -> r_resp SLVERR, r_data 0.
  - Assert aresetn low mid-read -> r_valid 0 immediately, and ar_ready=1 after release.
